// File: rtl/mtr_pkg.sv
// mtr_pkg: shared types and constants for the meter PI request path.
// State enum, PI function codes, EPT offsets and INCR_SEL encodings.
package mtr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANTED,
    HONOR
  } mtr_pi_state_t;

  localparam logic [2:0] FUNC_INCR   = 3'd1;
  localparam logic [2:0] FUNC_VECTOR = 3'd2;

  localparam logic [8:0] OFS_CNT_BASE = 9'o510;
  localparam logic [8:0] OFS_VECTOR   = 9'o520;

  localparam logic [1:0] INCR_TIME  = 2'd0;
  localparam logic [1:0] INCR_PERF  = 2'd1;
  localparam logic [1:0] INCR_EBOX  = 2'd2;
  localparam logic [1:0] INCR_CACHE = 2'd3;

  // level 0 maps to no request; level i sets bit i-1
  function automatic logic [6:0] pia_onehot(
    input logic [2:0] lvl
  );
    return 7'((8'd1 << lvl) >> 1);
  endfunction

  // counter slots are two words apart above the base
  function automatic logic [8:0] incr_ofs(
    input logic [1:0] sel
  );
    return OFS_CNT_BASE + {6'd0, sel, 1'b0};
  endfunction

endpackage

// File: rtl/mtr_pi_timer.sv
// mtr_pi_timer: clear/enable cycle counter with terminal flag.
// tc is asserted while enabled and the count sits at TIMEOUT-1.
module mtr_pi_timer #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // clear dominates; otherwise count while enabled
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/mtr_pi_req.sv
// mtr_pi_req: meter interrupt to PI request, grant tracking, honor.
// Optional MTR_PI_STATS_EN adds HONOR_CNT/TMO_CNT statistics.
module mtr_pi_req
  import mtr_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       INTERRUPT_REQ,
  input  logic       VECTOR_REQ,
  input  logic [1:0] INCR_SEL,
  input  logic [2:0] MTR_PIA,
  input  logic       PI_GRANT,
  input  logic [2:0] GRANT_LEVEL,
  input  logic       PI_CYCLE_DONE,
  output logic [6:0] PI_REQ,
  output logic       PI_ACTIVE,
  output logic [2:0] FUNC,
  output logic [8:0] ADDR_OFS,
  output logic       MTR_HONOR,
  output logic       ERR
`ifdef MTR_PI_STATS_EN
  ,
  output logic [15:0] HONOR_CNT,
  output logic [7:0]  TMO_CNT
`endif
);

  mtr_pi_state_t st, st_n;

  logic [6:0] req_n;
  logic       act_n;
  logic [2:0] func_n;
  logic [8:0] ofs_n;
  logic       hon_n;
  logic       err_n;
  logic       tclr;
  logic       ten;
  logic       tc;

  mtr_pi_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .RESET_N (RESET_N),
    .clr     (tclr),
    .en      (ten),
    .tc      (tc)
  );

  // state and all outputs are registered together
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      st        <= IDLE;
      PI_REQ    <= '0;
      PI_ACTIVE <= 1'b0;
      FUNC      <= '0;
      ADDR_OFS  <= '0;
      MTR_HONOR <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      st        <= st_n;
      PI_REQ    <= req_n;
      PI_ACTIVE <= act_n;
      FUNC      <= func_n;
      ADDR_OFS  <= ofs_n;
      MTR_HONOR <= hon_n;
      ERR       <= err_n;
    end
  end

  // next state and next output values
  always_comb begin
    st_n   = st;
    req_n  = '0;
    act_n  = PI_ACTIVE;
    func_n = FUNC;
    ofs_n  = ADDR_OFS;
    hon_n  = 1'b0;
    err_n  = ERR;
    tclr   = 1'b0;
    ten    = 1'b0;
    unique case (st)
      IDLE: begin
        if (INTERRUPT_REQ && (MTR_PIA != 3'd0)) begin
          st_n = REQ;
        end
      end
      REQ: begin
        if (!INTERRUPT_REQ || (MTR_PIA == 3'd0)) begin
          st_n = IDLE;
        end else if (PI_GRANT && (GRANT_LEVEL == MTR_PIA)) begin
          st_n   = GRANTED;
          act_n  = 1'b1;
          tclr   = 1'b1;
          func_n = VECTOR_REQ ? FUNC_VECTOR : FUNC_INCR;
          ofs_n  = VECTOR_REQ ? OFS_VECTOR : incr_ofs(INCR_SEL);
        end else begin
          req_n = pia_onehot(MTR_PIA);
        end
      end
      GRANTED: begin
        ten = 1'b1;
        if (PI_CYCLE_DONE) begin
          st_n   = HONOR;
          hon_n  = 1'b1;
          act_n  = 1'b0;
          func_n = '0;
          ofs_n  = '0;
        end else if (tc) begin
          st_n   = IDLE;
          err_n  = 1'b1;
          act_n  = 1'b0;
          func_n = '0;
          ofs_n  = '0;
        end
      end
      HONOR: begin
        st_n = IDLE;
      end
      default: begin
        st_n = IDLE;
      end
    endcase
  end

`ifdef MTR_PI_STATS_EN
  logic tmo;

  assign tmo = (st == GRANTED) && tc && !PI_CYCLE_DONE;

  // saturating honor and timeout statistics
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      HONOR_CNT <= '0;
      TMO_CNT   <= '0;
    end else begin
      if ((st == HONOR) && (HONOR_CNT != '1)) begin
        HONOR_CNT <= HONOR_CNT + 16'd1;
      end
      if (tmo && (TMO_CNT != '1)) begin
        TMO_CNT <= TMO_CNT + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mtr_pi_req.sv
// tb_mtr_pi_req: transaction-level random and directed bench.
// Define MTR_PI_STATS_EN to also check HONOR_CNT/TMO_CNT.
module tb_mtr_pi_req;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       INTERRUPT_REQ;
  logic       VECTOR_REQ;
  logic [1:0] INCR_SEL;
  logic [2:0] MTR_PIA;
  logic       PI_GRANT;
  logic [2:0] GRANT_LEVEL;
  logic       PI_CYCLE_DONE;
  logic [6:0] PI_REQ;
  logic       PI_ACTIVE;
  logic [2:0] FUNC;
  logic [8:0] ADDR_OFS;
  logic       MTR_HONOR;
  logic       ERR;
`ifdef MTR_PI_STATS_EN
  logic [15:0] HONOR_CNT;
  logic [7:0]  TMO_CNT;
`endif

  int checks = 0;
  int errors = 0;
  int m_err  = 0;
  int m_hon  = 0;
  int m_tmo  = 0;

  always #5 clk = ~clk;

  mtr_pi_req #(
    .TIMEOUT (TMO),
    .TW      (7)
  ) dut (
    .clk           (clk),
    .RESET_N       (RESET_N),
    .INTERRUPT_REQ (INTERRUPT_REQ),
    .VECTOR_REQ    (VECTOR_REQ),
    .INCR_SEL      (INCR_SEL),
    .MTR_PIA       (MTR_PIA),
    .PI_GRANT      (PI_GRANT),
    .GRANT_LEVEL   (GRANT_LEVEL),
    .PI_CYCLE_DONE (PI_CYCLE_DONE),
    .PI_REQ        (PI_REQ),
    .PI_ACTIVE     (PI_ACTIVE),
    .FUNC          (FUNC),
    .ADDR_OFS      (ADDR_OFS),
    .MTR_HONOR     (MTR_HONOR),
    .ERR           (ERR)
`ifdef MTR_PI_STATS_EN
    ,
    .HONOR_CNT     (HONOR_CNT),
    .TMO_CNT       (TMO_CNT)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_req(input int pia);
    return 7'(1 << (pia - 1));
  endfunction

  function automatic logic [8:0] exp_ofs(input int vec, input int sel);
    return (vec != 0) ? 9'o520 : 9'(9'o510 + 2 * sel);
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_req"}, 32'(PI_REQ), 0);
    chk({tag, "_act"}, 32'(PI_ACTIVE), 0);
    chk({tag, "_func"}, 32'(FUNC), 0);
    chk({tag, "_ofs"}, 32'(ADDR_OFS), 0);
    chk({tag, "_hon"}, 32'(MTR_HONOR), 0);
  endtask

  // one complete meter interrupt seen from the PI side;
  // dd = cycles in GRANTED without done (>= TMO means timeout)
  task automatic txn(
    input int pia, input int vec, input int sel,
    input int wt, input int bad, input int dd,
    input int keep, input int abort
  );
    int fe;
    logic [8:0] oe;
    INTERRUPT_REQ = 1'b1;
    MTR_PIA       = 3'(pia);
    VECTOR_REQ    = 1'(vec);
    INCR_SEL      = 2'(sel);
    PI_GRANT      = 1'b0;
    PI_CYCLE_DONE = 1'b0;
    step;
    chk("req_lat1", 32'(PI_REQ), 0);
    step;
    chk("req_on", 32'(PI_REQ), 32'(exp_req(pia)));
    chk("act_pre", 32'(PI_ACTIVE), 0);
    if (abort != 0) begin
      INTERRUPT_REQ = 1'b0;
      step;
      chk("abort_req", 32'(PI_REQ), 0);
      step;
      chk("abort_hon", 32'(MTR_HONOR), 0);
      chk("abort_act", 32'(PI_ACTIVE), 0);
      return;
    end
    for (int i = 0; i < wt; i++) begin
      if (bad != 0) begin
        PI_GRANT    = 1'b1;
        GRANT_LEVEL = 3'((pia + $urandom_range(1, 7)) % 8);
      end
      step;
      chk("req_hold", 32'(PI_REQ), 32'(exp_req(pia)));
      chk("act_hold0", 32'(PI_ACTIVE), 0);
    end
    PI_GRANT    = 1'b1;
    GRANT_LEVEL = 3'(pia);
    step;
    PI_GRANT = 1'b0;
    fe = (vec != 0) ? 2 : 1;
    oe = exp_ofs(vec, sel);
    chk("gnt_act", 32'(PI_ACTIVE), 1);
    chk("gnt_func", 32'(FUNC), 32'(fe));
    chk("gnt_ofs", 32'(ADDR_OFS), 32'(oe));
    chk("gnt_req", 32'(PI_REQ), 0);
    for (int i = 0; i < dd && i < TMO; i++) begin
      VECTOR_REQ = 1'($urandom);
      INCR_SEL   = 2'($urandom);
      MTR_PIA    = 3'($urandom);
      step;
      if (i < TMO - 1) begin
        chk("held_act", 32'(PI_ACTIVE), 1);
        chk("held_func", 32'(FUNC), 32'(fe));
        chk("held_ofs", 32'(ADDR_OFS), 32'(oe));
        chk("held_hon", 32'(MTR_HONOR), 0);
      end else begin
        m_err = 1;
        m_tmo++;
        chk("tmo_act", 32'(PI_ACTIVE), 0);
        chk("tmo_hon", 32'(MTR_HONOR), 0);
        chk("tmo_err", 32'(ERR), 1);
      end
    end
    if (dd < TMO) begin
      PI_CYCLE_DONE = 1'b1;
      step;
      PI_CYCLE_DONE = 1'b0;
      m_hon++;
      chk("hon_pulse", 32'(MTR_HONOR), 1);
      chk("hon_act", 32'(PI_ACTIVE), 0);
      chk("hon_func", 32'(FUNC), 0);
      chk("hon_ofs", 32'(ADDR_OFS), 0);
    end
    if (keep != 0) begin
      VECTOR_REQ = 1'b0;
      INCR_SEL   = 2'd1;
    end else begin
      INTERRUPT_REQ = 1'b0;
    end
    step;
    chk("hon_one", 32'(MTR_HONOR), 0);
    chk("post_req", 32'(PI_REQ), 0);
    chk("err", 32'(ERR), 32'(m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int pia, dd, r, keep;
    RESET_N       = 1'b0;
    INTERRUPT_REQ = 1'b0;
    VECTOR_REQ    = 1'b0;
    INCR_SEL      = 2'd0;
    MTR_PIA       = 3'd0;
    PI_GRANT      = 1'b0;
    GRANT_LEVEL   = 3'd0;
    PI_CYCLE_DONE = 1'b0;
    step;
    step;
    chk_idle_outs("rst");
    chk("rst_err", 32'(ERR), 0);
    RESET_N = 1'b1;
    step;

    // incr on perf/ebox slot, then vector at level 7
    txn(3, 0, 2, 0, 0, 5, 0, 0);
    txn(7, 1, 0, 1, 1, 2, 0, 0);

    // disabled level, level change in REQ, wrong-level grant
    INTERRUPT_REQ = 1'b1;
    MTR_PIA       = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("pia0_req", 32'(PI_REQ), 0);
    end
    MTR_PIA = 3'd5;
    step;
    chk("pia5_lat", 32'(PI_REQ), 0);
    step;
    chk("pia5_req", 32'(PI_REQ), 32'h10);
    MTR_PIA = 3'd2;
    step;
    chk("pia2_req", 32'(PI_REQ), 32'h02);
    PI_GRANT    = 1'b1;
    GRANT_LEVEL = 3'd5;
    step;
    PI_GRANT = 1'b0;
    chk("badgnt_req", 32'(PI_REQ), 32'h02);
    chk("badgnt_act", 32'(PI_ACTIVE), 0);
    INTERRUPT_REQ = 1'b0;
    step;
    chk("drop_req", 32'(PI_REQ), 0);
    step;
    chk("drop_hon", 32'(MTR_HONOR), 0);

    // done on the last allowed cycle, then a full timeout
    txn(2, 0, 0, 0, 0, TMO - 1, 0, 0);
    txn(1, 0, 3, 0, 0, TMO, 0, 0);
`ifdef MTR_PI_STATS_EN
    chk("tmo_cnt1", 32'(TMO_CNT), 1);
`endif
    txn(4, 1, 1, 0, 0, 1, 0, 1);

    // reset while GRANTED
    INTERRUPT_REQ = 1'b1;
    MTR_PIA       = 3'd6;
    step;
    step;
    PI_GRANT    = 1'b1;
    GRANT_LEVEL = 3'd6;
    step;
    PI_GRANT = 1'b0;
    step;
    chk("prerst_act", 32'(PI_ACTIVE), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_idle_outs("midrst");
    chk("midrst_err", 32'(ERR), 0);
    m_err = 0;
    m_hon = 0;
    m_tmo = 0;
    INTERRUPT_REQ = 1'b0;
    PI_CYCLE_DONE = 1'b1;
    step;
    RESET_N = 1'b1;
    step;
    chk("postrst_hon", 32'(MTR_HONOR), 0);
    step;
    chk("postrst_hon2", 32'(MTR_HONOR), 0);
    PI_CYCLE_DONE = 1'b0;

    // back-to-back: request held across HONOR
    txn(4, 0, 3, 0, 0, 3, 1, 0);
    txn(4, 0, 1, 0, 0, 2, 0, 0);

    for (int n = 0; n < 40; n++) begin
      pia  = int'($urandom_range(1, 7));
      r    = int'($urandom_range(0, 9));
      dd   = (r == 0) ? TMO - 1 :
             (r == 1) ? TMO : int'($urandom_range(0, 8));
      keep = (dd < TMO && $urandom_range(0, 3) == 0) ? 1 : 0;
      txn(pia, int'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 1)), dd, keep,
          ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
    INTERRUPT_REQ = 1'b0;
    step;
    step;
    chk_idle_outs("end");
`ifdef MTR_PI_STATS_EN
    chk("honor_cnt", 32'(HONOR_CNT), 32'(m_hon));
    chk("tmo_cnt", 32'(TMO_CNT), 32'(m_tmo));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
